// File: rtl/tbus_responder.sv
// Trinity Bus responder: single-outstanding request, serviced from an
// internal word-addressed array after a fixed LATENCY, completion signalled
// by a one-cycle tbus_operation_done pulse.
module tbus_responder #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 64,
    parameter int DEPTH    = 1024,
    parameter int LATENCY  = 2,
    parameter int OPTYPE_W = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tbus_index_valid,
    output logic                tbus_index_ready,
    input  logic [ADDR_W-1:0]   tbus_index,
    input  logic [OPTYPE_W-1:0] tbus_operation_type,
    input  logic [DATA_W-1:0]   tbus_write_data,
    input  logic [DATA_W-1:0]   tbus_write_mask,
    output logic [DATA_W-1:0]   tbus_read_data,
    output logic                tbus_operation_done
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [OPTYPE_W-1:0] OP_READ  = OPTYPE_W'(1);
    localparam logic [OPTYPE_W-1:0] OP_WRITE = OPTYPE_W'(2);

    // BUSY is left once the counter reaches 1 (or starts at 0), so the
    // done pulse lands LATENCY cycles after the accept cycle; LATENCY=1
    // still spends one cycle in BUSY to let the array read settle.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    // Control state
    logic [1:0]          state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // Latched request
    logic [AW-1:0]       word_q, word_d;
    logic [OPTYPE_W-1:0] op_q, op_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   wmask_q, wmask_d;

    // Array and its access port
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   mem_rd_q;
    logic [AW-1:0]       mem_rd_addr;
    logic [DATA_W-1:0]   mem_wr_data;
    logic                mem_we;

    logic                accept;
    logic                commit;
    logic [AW-1:0]       in_word;
    logic                unused_index_bits;

    // Upper address bits alias and the byte offset is irrelevant for a
    // word-wide array.
    assign in_word           = tbus_index[AW+2:3];
    assign unused_index_bits = ^{tbus_index[ADDR_W-1:AW+3], tbus_index[2:0]};

    assign accept = tbus_index_valid && (state_q == ST_IDLE);
    assign commit = (state_q == ST_BUSY) && (cnt_q <= 4'd1);

    // The array is read every cycle; on the accept edge it fetches the new
    // word so the old contents are ready by the commit edge.
    assign mem_rd_addr = accept ? in_word : word_q;

    // A write is dropped when reset coincides with its commit edge.
    assign mem_we = commit && (op_q == OP_WRITE) && !reset;

    // Per-bit merge of store data over the current word contents.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_merge
            assign mem_wr_data[gi] = wmask_q[gi] ? wdata_q[gi] : mem_rd_q[gi];
        end
    endgenerate

    // Next-state, counter and response-data computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        word_d  = word_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                    word_d  = in_word;
                    op_d    = tbus_operation_type;
                    wdata_d = tbus_write_data;
                    wmask_d = tbus_write_mask;
                end
            end
            ST_BUSY: begin
                if (commit) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                    if (op_q == OP_READ) begin
                        rdata_d = mem_rd_q;
                    end else if (op_q != OP_WRITE) begin
                        rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Request holding registers; only meaningful while a request is open
    always_ff @(posedge clock) begin
        word_q  <= word_d;
        op_q    <= op_d;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
    end

    // Word array: registered read, single write port, contents not reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[word_q] <= mem_wr_data;
        end
        mem_rd_q <= mem[mem_rd_addr];
    end

    assign tbus_index_ready    = (state_q == ST_IDLE);
    assign tbus_operation_done = (state_q == ST_RESP);
    assign tbus_read_data      = rdata_q;

endmodule

// File: tb/tb_tbus_responder.sv
// Directed bench for tbus_responder with default parameters.
module tb_tbus_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        tbus_index_valid;
    logic        tbus_index_ready;
    logic [63:0] tbus_index;
    logic [1:0]  tbus_operation_type;
    logic [63:0] tbus_write_data;
    logic [63:0] tbus_write_mask;
    logic [63:0] tbus_read_data;
    logic        tbus_operation_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MERGED  = 64'h1122_3344_FFFF_7788;

    tbus_responder dut (
        .clock               (clock),
        .reset               (reset),
        .tbus_index_valid    (tbus_index_valid),
        .tbus_index_ready    (tbus_index_ready),
        .tbus_index          (tbus_index),
        .tbus_operation_type (tbus_operation_type),
        .tbus_write_data     (tbus_write_data),
        .tbus_write_mask     (tbus_write_mask),
        .tbus_read_data      (tbus_read_data),
        .tbus_operation_done (tbus_operation_done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Issue one request and wait for its completion; lat = -1 on timeout.
    task automatic issue(input logic [63:0] idx, input logic [1:0] op,
                         input logic [63:0] wd, input logic [63:0] m,
                         output logic [63:0] rd, output int lat);
        int n;
        int acc;
        n = 0;
        while (!tbus_index_ready && n < 50) begin
            @(posedge clock); #1; n++;
        end
        acc = cyc;
        tbus_index_valid    = 1'b1;
        tbus_index          = idx;
        tbus_operation_type = op;
        tbus_write_data     = wd;
        tbus_write_mask     = m;
        @(posedge clock); #1;
        tbus_index_valid = 1'b0;
        n = 0;
        while (!tbus_operation_done && n < 20) begin
            @(posedge clock); #1; n++;
        end
        lat = tbus_operation_done ? (cyc - acc) : -1;
        rd  = tbus_read_data;
        $display("txn op=%b idx=0x%h wdata=0x%h mask=0x%h -> lat=%0d rdata=0x%h",
                 op, idx, wd, m, lat, rd);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tbus_index_valid = 1'b0;
        tbus_index = '0; tbus_operation_type = 2'b00;
        tbus_write_data = '0; tbus_write_mask = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (tbus_index_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", tbus_index_ready); end
        checks++; if (tbus_operation_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", tbus_operation_done); end
        checks++; if (tbus_read_data !== 64'h0) begin errors++; $display("FAIL reset_rdata got 0x%h want 0", tbus_read_data); end
        // valid together with reset must not be accepted
        tbus_index_valid = 1'b1; tbus_index = 64'h40; tbus_operation_type = 2'b01;
        @(posedge clock); #1;
        reset = 1'b0; tbus_index_valid = 1'b0;
        checks++; if (tbus_index_ready !== 1'b1) begin errors++; $display("FAIL reset_valid_ready got %b want 1", tbus_index_ready); end
        @(posedge clock); #1;
        checks++; if (tbus_operation_done !== 1'b0) begin errors++; $display("FAIL reset_valid_done got %b want 0", tbus_operation_done); end
        checks++; if (tbus_index_ready !== 1'b1) begin errors++; $display("FAIL reset_valid_ready2 got %b want 1", tbus_index_ready); end
    endtask

    task automatic test_write_read();
        logic [63:0] rd; int lat;
        issue(64'h40, 2'b10, 64'h1122_3344_5566_7788, ONES, rd, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency got %0d want 2", lat); end
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL wr_rdata_untouched got 0x%h want 0", rd); end
        issue(64'h40, 2'b01, '0, '0, rd, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency got %0d want 2", lat); end
        checks++; if (rd !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL rd_data got 0x%h want 0x1122334455667788", rd); end
    endtask

    task automatic test_partial_mask();
        logic [63:0] rd; int lat;
        issue(64'h40, 2'b10, ONES, 64'h0000_0000_FFFF_0000, rd, lat);
        issue(64'h40, 2'b01, '0, '0, rd, lat);
        checks++; if (rd !== MERGED) begin errors++; $display("FAIL partial_mask got 0x%h want 0x%h", rd, MERGED); end
        // all-zero mask completes without changing memory
        issue(64'h40, 2'b10, 64'h0, 64'h0, rd, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL zero_mask_latency got %0d want 2", lat); end
        issue(64'h40, 2'b01, '0, '0, rd, lat);
        checks++; if (rd !== MERGED) begin errors++; $display("FAIL zero_mask_data got 0x%h want 0x%h", rd, MERGED); end
    endtask

    task automatic test_alias();
        logic [63:0] rd; int lat;
        issue(64'h2000, 2'b10, 64'hA5, ONES, rd, lat);
        issue(64'h0, 2'b01, '0, '0, rd, lat);
        checks++; if (rd !== 64'hA5) begin errors++; $display("FAIL alias_upper got 0x%h want 0xa5", rd); end
        issue(64'h2005, 2'b01, '0, '0, rd, lat);
        checks++; if (rd !== 64'hA5) begin errors++; $display("FAIL alias_lowbits got 0x%h want 0xa5", rd); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] idx [3];
        logic [63:0] exp [3];
        int n;
        idx[0] = 64'h40;  exp[0] = MERGED;
        idx[1] = 64'h0;   exp[1] = 64'hA5;
        idx[2] = 64'h48;  exp[2] = 64'h0;
        // word 9 gets a known value first
        begin
            logic [63:0] rd; int lat;
            issue(64'h48, 2'b10, 64'h0, ONES, rd, lat);
        end
        n = 0;
        while (!tbus_index_ready && n < 50) begin @(posedge clock); #1; n++; end
        for (int k = 0; k < 10; k++) begin
            tbus_index_valid = (k <= 6);
            tbus_operation_type = 2'b01;
            if (k <= 6) tbus_index = idx[k/3];
            checks++;
            if (tbus_index_ready !== (k % 3 == 0)) begin
                errors++; $display("FAIL b2b_ready k=%0d got %b want %b", k, tbus_index_ready, (k % 3 == 0));
            end
            checks++;
            if (tbus_operation_done !== (k % 3 == 2)) begin
                errors++; $display("FAIL b2b_done k=%0d got %b want %b", k, tbus_operation_done, (k % 3 == 2));
            end
            if (k % 3 == 2) begin
                checks++;
                if (tbus_read_data !== exp[k/3]) begin
                    errors++; $display("FAIL b2b_data k=%0d got 0x%h want 0x%h", k, tbus_read_data, exp[k/3]);
                end
                $display("txn b2b read idx=0x%h rdata=0x%h", idx[k/3], tbus_read_data);
            end
            @(posedge clock); #1;
        end
        tbus_index_valid = 1'b0;
    endtask

    task automatic test_illegal();
        logic [63:0] rd; int lat;
        issue(64'h40, 2'b01, '0, '0, rd, lat);  // read_data nonzero beforehand
        issue(64'h40, 2'b11, ONES, ONES, rd, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL illegal_latency got %0d want 2", lat); end
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL illegal_rdata got 0x%h want 0", rd); end
        issue(64'h40, 2'b00, ONES, ONES, rd, lat);
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL illegal00_rdata got 0x%h want 0", rd); end
        issue(64'h40, 2'b01, '0, '0, rd, lat);
        checks++; if (rd !== MERGED) begin errors++; $display("FAIL illegal_nowrite got 0x%h want 0x%h", rd, MERGED); end
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] rd; int lat; int n;
        issue(64'h80, 2'b10, 64'h0, ONES, rd, lat);
        n = 0;
        while (!tbus_index_ready && n < 50) begin @(posedge clock); #1; n++; end
        tbus_index_valid = 1'b1; tbus_index = 64'h80; tbus_operation_type = 2'b10;
        tbus_write_data = 64'hDEAD; tbus_write_mask = ONES;
        @(posedge clock); #1;
        tbus_index_valid = 1'b0;
        reset = 1'b1;
        checks++; if (tbus_index_ready !== 1'b0) begin errors++; $display("FAIL midrst_busy_ready got %b want 0", tbus_index_ready); end
        @(posedge clock); #1;
        reset = 1'b0;
        checks++; if (tbus_operation_done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", tbus_operation_done); end
        checks++; if (tbus_index_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", tbus_index_ready); end
        $display("txn aborted write idx=0x80 wdata=0xdead");
        issue(64'h80, 2'b01, '0, '0, rd, lat);
        checks++; if (rd !== 64'h0) begin errors++; $display("FAIL midrst_mem got 0x%h want 0", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL midrst_latency got %0d want 2", lat); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_mask();
        test_alias();
        test_back_to_back();
        test_illegal();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
